// File: rtl/aes128_decryptor.sv
// aes128_decryptor: iterative AES-128 inverse cipher, one round per clock.
// The key schedule is run forward to rk10, then stepped backwards alongside the rounds.
module aes128_decryptor (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] ciphertext,
  input  logic [127:0] key,
  output logic [127:0] plaintext,
  output logic         done,
  output logic         busy
);
  typedef enum logic [2:0] {IDLE, EXPAND, ADDKEY, ROUND, FINAL} state_t;
  state_t r_fsm, w_fsm_nx;
  logic [3:0] r_cnt, w_cnt_nx;
  logic [127:0] r_st, r_key, w_st_nx, w_key_nx, w_fwd_key, w_inv_key, w_inv_sb, w_imc;
  logic [31:0] w_sw_in, w_t;
  logic [7:0] w_rc;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] a2, a3, a12, a15, a240;
    a2 = gmul(a, a);
    a3 = gmul(a2, a);
    a12 = gmul(gmul(a3, a3), gmul(a3, a3));
    a15 = gmul(a12, a3);
    a240 = gmul(a15, a15);
    a240 = gmul(a240, a240);
    a240 = gmul(a240, a240);
    a240 = gmul(a240, a240);
    return gmul(gmul(a240, a12), a2);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    return i < 4'd8 ? 8'h01 << i : (i == 4'd8 ? 8'h1b : 8'h36);
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    int b;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      b = i - i % 4;
      o[127-8*i -: 8] = gmul(s[127-8*(b + i % 4) -: 8], 8'h0e) ^ gmul(s[127-8*(b + (i + 1) % 4) -: 8], 8'h0b)
                      ^ gmul(s[127-8*(b + (i + 2) % 4) -: 8], 8'h0d) ^ gmul(s[127-8*(b + (i + 3) % 4) -: 8], 8'h09);
    end
    return o;
  endfunction

  // One SubWord(RotWord()) is shared: forward steps feed w3, inverse steps feed w7^w6.
  always_comb begin
    w_sw_in = (r_fsm == EXPAND) ? r_key[31:0] : r_key[63:32] ^ r_key[31:0];
    w_rc = rcon((r_fsm == EXPAND) ? r_cnt : r_cnt - 4'd1);
    w_t = {sbox(w_sw_in[23:16]), sbox(w_sw_in[15:8]), sbox(w_sw_in[7:0]), sbox(w_sw_in[31:24])} ^ {w_rc, 24'h0};
    w_fwd_key[127:96] = r_key[127:96] ^ w_t;
    w_fwd_key[95:64] = r_key[95:64] ^ w_fwd_key[127:96];
    w_fwd_key[63:32] = r_key[63:32] ^ w_fwd_key[95:64];
    w_fwd_key[31:0] = r_key[31:0] ^ w_fwd_key[63:32];
    w_inv_key = {r_key[127:96] ^ w_t, r_key[127:96] ^ r_key[95:64], r_key[95:64] ^ r_key[63:32], r_key[63:32] ^ r_key[31:0]};
    w_inv_sb = '0;
    for (int i = 0; i < 16; i++)
      w_inv_sb[127-8*i -: 8] = inv_sbox(r_st[127-8*(i % 4 + 4*((i / 4 - i % 4 + 4) % 4)) -: 8]);
    w_imc = inv_mix(w_inv_sb ^ r_key);
  end

  always_comb begin
    w_fsm_nx = r_fsm;
    w_cnt_nx = r_cnt;
    w_st_nx = r_st;
    w_key_nx = r_key;
    case (r_fsm)
      IDLE: if (start) begin
        w_fsm_nx = EXPAND;
        w_cnt_nx = 4'd0;
        w_st_nx = ciphertext;
        w_key_nx = key;
      end
      EXPAND: begin
        w_key_nx = w_fwd_key;
        w_cnt_nx = r_cnt + 4'd1;
        w_fsm_nx = (r_cnt == 4'd9) ? ADDKEY : EXPAND;
      end
      ADDKEY: begin
        w_st_nx = r_st ^ r_key;
        w_key_nx = w_inv_key;
        w_cnt_nx = 4'd9;
        w_fsm_nx = ROUND;
      end
      ROUND: begin
        w_st_nx = w_imc;
        w_key_nx = w_inv_key;
        w_cnt_nx = r_cnt - 4'd1;
        w_fsm_nx = (r_cnt == 4'd1) ? FINAL : ROUND;
      end
      default: w_fsm_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fsm <= IDLE;
      r_cnt <= '0;
      r_st <= '0;
      r_key <= '0;
      plaintext <= '0;
      done <= 1'b0;
    end else begin
      r_fsm <= w_fsm_nx;
      r_cnt <= w_cnt_nx;
      r_st <= w_st_nx;
      r_key <= w_key_nx;
      done <= (r_fsm == FINAL);
      if (r_fsm == FINAL) plaintext <= w_inv_sb ^ r_key;
    end
  end

  assign busy = (r_fsm != IDLE);
endmodule

// File: tb/tb_aes128_decryptor.sv
// tb_aes128_decryptor: vector table plus hand sequences; a scoreboard checks every done pulse.
// The reference encryptor builds its S-box by walking the multiplicative group of GF(2^8).
module tb_aes128_decryptor;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [127:0] ct_i = '0, key_i = '0, plaintext;
  logic done, busy;
  int cyc = 0, passes = 0, total = 0, n_done = 0;

  typedef struct {logic [127:0] k; logic [127:0] ct; logic [127:0] pt;} vec_t;
  typedef struct {logic [127:0] pt; int e0;} exp_t;
  vec_t vecs[6];
  exp_t sb[$];
  exp_t e;
  logic [7:0] sbx[256];

  aes128_decryptor dut (.clk(clk), .rst(rst), .start(start), .ciphertext(ct_i), .key(key_i),
                        .plaintext(plaintext), .done(done), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  always @(negedge clk) if (rst && done) begin
    n_done++;
    if (sb.size() == 0) begin
      total++;
      $display("FAIL unexpected_done: got done with empty scoreboard at cycle %0d, want no pulse", cyc);
    end else begin
      e = sb.pop_front();
      chk("plaintext", plaintext, e.pt);
      chk("latency", 128'(cyc - e.e0), 128'd21);
    end
  end

  function automatic logic [7:0] gb(input logic [127:0] v, input int i);
    return v[127-8*i -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] ks(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2;
    t = {sbx[k[23:16]], sbx[k[15:8]], sbx[k[7:0]], sbx[k[31:24]]} ^ {rc, 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    return {w0, w1, w2, k[31:0] ^ w2};
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] k);
    logic [127:0] s, rk, t, m;
    logic [7:0] rc, a0, a1, a2, a3;
    s = pt ^ k;
    rk = k;
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      rk = ks(rk, rc);
      rc = xt(rc);
      for (int i = 0; i < 16; i++) t[127-8*i -: 8] = sbx[gb(s, i % 4 + 4*((i / 4 + i % 4) % 4))];
      m = t;
      if (r < 10)
        for (int c = 0; c < 4; c++) begin
          a0 = gb(t, 4*c); a1 = gb(t, 4*c+1); a2 = gb(t, 4*c+2); a3 = gb(t, 4*c+3);
          m[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3, a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                               a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3, xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
        end
      s = m ^ rk;
    end
    return s;
  endfunction

  task automatic go(input logic [127:0] k, input logic [127:0] ct, input logic [127:0] pt);
    key_i = k;
    ct_i = ct;
    start = 1'b1;
    sb.push_back('{pt: pt, e0: cyc + 1});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      total++;
      $display("FAIL timeout: got %0d pending results after 60 cycles, want 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    logic [7:0] p, q;
    int nd, n;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      sbx[p] = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]} ^ 8'h63;
    end while (p != 8'h01);
    sbx[0] = 8'h63;
    vecs[0] = '{k: 128'h000102030405060708090a0b0c0d0e0f, ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                pt: 128'h00112233445566778899aabbccddeeff};
    vecs[1] = '{k: 128'h2b7e151628aed2a6abf7158809cf4f3c, ct: 128'h3925841d02dc09fbdc118597196a0b32,
                pt: 128'h3243f6a8885a308d313198a2e0370734};
    vecs[2].k = 128'h6772696666696e746772696666696e74;
    vecs[2].pt = 128'h636f6d7061726368636f6d7061726368;
    vecs[2].ct = aes_enc(vecs[2].pt, vecs[2].k);
    for (int i = 3; i < 6; i++) begin
      vecs[i].k = {$urandom, $urandom, $urandom, $urandom};
      vecs[i].pt = {$urandom, $urandom, $urandom, $urandom};
      vecs[i].ct = aes_enc(vecs[i].pt, vecs[i].k);
    end
    chk("model_v1", aes_enc(vecs[0].pt, vecs[0].k), vecs[0].ct);

    repeat (2) @(negedge clk);
    chk("rst_plaintext", plaintext, 128'h0);
    chk("rst_done", 128'(done), 128'h0);
    chk("rst_busy", 128'(busy), 128'h0);
    rst = 1'b1;
    @(negedge clk);

    go(vecs[0].k, vecs[0].ct, vecs[0].pt);
    chk("busy_e0", 128'(busy), 128'h1);
    repeat (20) @(negedge clk);
    chk("busy_e20", 128'(busy), 128'h1);
    chk("done_e20", 128'(done), 128'h0);
    @(negedge clk);
    chk("done_e21", 128'(done), 128'h1);
    chk("busy_e21", 128'(busy), 128'h0);
    @(negedge clk);
    chk("done_e22", 128'(done), 128'h0);
    chk("pt_hold", plaintext, vecs[0].pt);

    for (int i = 0; i < 6; i++) begin
      go(vecs[i].k, vecs[i].ct, vecs[i].pt);
      wait_idle();
    end

    nd = n_done;
    go(vecs[0].k, vecs[0].ct, vecs[0].pt);
    repeat (4) @(negedge clk);
    key_i = vecs[1].k;
    ct_i = vecs[1].ct;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (25) @(negedge clk);
    chk("busy_start_one_done", 128'(n_done - nd), 128'd1);

    go(vecs[0].k, vecs[0].ct, vecs[0].pt);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      total++;
      $display("FAIL b2b_first_done: got no done within 40 cycles, want one");
    end
    go(vecs[1].k, vecs[1].ct, vecs[1].pt);
    chk("b2b_busy", 128'(busy), 128'h1);
    wait_idle();

    go(vecs[1].k, vecs[1].ct, vecs[1].pt);
    repeat (12) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_plaintext", plaintext, 128'h0);
    chk("abort_done", 128'(done), 128'h0);
    chk("abort_busy", 128'(busy), 128'h0);
    sb.delete();
    nd = n_done;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (25) @(negedge clk);
    chk("abort_no_done", 128'(n_done - nd), 128'd0);
    go(vecs[0].k, vecs[0].ct, vecs[0].pt);
    wait_idle();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
